// File: rtl/led_accum_ctrl.sv
// Thresholded per-channel sample accumulator with a 3-state accept/arm/accumulate FSM and LED byte view.
// Optional build macro LED_ACCUM_SAT_EN: saturate accumulators instead of wrapping.
module led_accum_ctrl #(
  parameter int DATA_W     = 8,
  parameter int NCH        = 4,
  parameter int ACC_W      = 32,
  parameter int THRESH     = 7,
  parameter int SEL_THRESH = 11,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [CH_W-1:0]   led_sel,
  output logic [ACC_W-1:0]  acc_out,
  output logic [NCH-1:0]    ovf,
  output logic              busy,
  output logic [7:0]        led
);

  localparam logic [DATA_W-1:0] THR_V = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] SEL_V = DATA_W'(SEL_THRESH);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

  state_t                       state, state_nxt;
  logic [DATA_W-1:0]            dat_q, last_val;
  logic [CH_W-1:0]              ch_q;
  logic [NCH-1:0][ACC_W-1:0]    acc;
  logic [ACC_W:0]               sum;
  logic [ACC_W-1:0]             acc_nxt;
  logic                         hs, take, ch_ok, sel_ok;

  assign in_ready = (state == IDLE) && enable && !clr;
  assign hs       = in_valid && in_ready;
  assign ch_ok    = 32'(in_ch) < NCH;
  // Low samples and out-of-range channels are consumed without leaving IDLE
  assign take     = hs && (in_data > THR_V) && ch_ok;

  assign sum = {1'b0, acc[ch_q]} + (ACC_W+1)'(dat_q);
`ifdef LED_ACCUM_SAT_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ARM;
      ARM:     state_nxt = ACCUM;
      ACCUM:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      acc      <= '0;
      ovf      <= '0;
      last_val <= '0;
      dat_q    <= '0;
      ch_q     <= '0;
    end else if (clr) begin
      // Clear wins over an accumulate completing on the same edge
      state    <= IDLE;
      acc      <= '0;
      ovf      <= '0;
      last_val <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        dat_q <= in_data;
        ch_q  <= in_ch;
      end
      if (state == ACCUM) begin
        acc[ch_q] <= acc_nxt;
        if (sum[ACC_W]) ovf[ch_q] <= 1'b1;
        last_val  <= dat_q;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign sel_ok  = 32'(led_sel) < NCH;
  assign acc_out = sel_ok ? acc[led_sel] : '0;
  assign led     = (last_val > SEL_V) ? acc_out[15:8] : acc_out[7:0];

endmodule

// File: tb/tb_led_accum_ctrl.sv
// Directed bench for led_accum_ctrl: a 32-bit instance for protocol checks and a 16-bit
// instance (same stimulus) for the wrap/saturate boundary.
module tb_led_accum_ctrl;

  logic        CLK = 1'b0;
  logic        RST, enable, clr, in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_ch, led_sel;

  logic        in_ready, busy, in_ready16, busy16;
  logic [31:0] acc_out;
  logic [15:0] acc_out16;
  logic [3:0]  ovf, ovf16;
  logic [7:0]  led, led16;

  int n_vec = 0;
  int n_err = 0;

  led_accum_ctrl #(.ACC_W(32)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch), .led_sel(led_sel),
    .acc_out(acc_out), .ovf(ovf), .busy(busy), .led(led)
  );

  led_accum_ctrl #(.ACC_W(16)) dut16 (
    .CLK(CLK), .RST(RST), .enable(enable), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready16), .in_data(in_data), .in_ch(in_ch), .led_sel(led_sel),
    .acc_out(acc_out16), .ovf(ovf16), .busy(busy16), .led(led16)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one sample for one edge; accepted samples then run through ARM and ACCUM
  task automatic send(input logic [7:0] d, input logic [1:0] c, input bit full);
    in_valid = 1'b1; in_data = d; in_ch = c;
    step();
    in_valid = 1'b0;
    if (full) begin
      step();
      step();
    end
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ch = '0; led_sel = '0;
    step(); step();
    RST = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_led", led, 8'h00);
    chk("rst_ovf", ovf, 4'h0);
    chk("rst_rdy_dis", in_ready, 0);
    enable = 1'b1; #1;
    chk("rst_rdy_en", in_ready, 1);

    // Low sample is consumed and dropped
    send(8'd5, 2'd0, 0);
    chk("low_acc", acc_out, 0);
    chk("low_busy", busy, 0);
    chk("low_rdy", in_ready, 1);
    send(8'd7, 2'd0, 0);
    chk("thr_eq_busy", busy, 0);
    send(8'd8, 2'd0, 1);
    chk("thr_gt_acc", acc_out, 8);

    // Latency: handshake at edge N, update visible after N+2
    led_sel = 2'd2;
    send(8'd20, 2'd2, 0);
    chk("n_rdy", in_ready, 0);
    chk("n_busy", busy, 1);
    step();
    chk("n1_rdy", in_ready, 0);
    chk("n1_acc", acc_out, 0);
    step();
    chk("n2_acc", acc_out, 20);
    chk("n2_led_hi", led, 8'h00);
    chk("n2_rdy", in_ready, 1);
    send(8'd9, 2'd2, 1);
    chk("acc29", acc_out, 29);
    chk("led_lo", led, 8'h1D);
    send(8'd11, 2'd2, 1);
    chk("sel_eq_led", led, 8'd40);
    send(8'd12, 2'd2, 1);
    chk("sel_gt_led", led, 8'h00);
    led_sel = 2'd0; #1;
    chk("ch0_iso", acc_out, 8);

    // clr during ACCUM discards the update
    led_sel = 2'd3;
    send(8'd10, 2'd3, 1);
    chk("ch3_10", acc_out, 10);
    send(8'd50, 2'd3, 0);
    step();
    chk("accum_busy", busy, 1);
    clr = 1'b1; #1;
    chk("clr_rdy", in_ready, 0);
    step();
    clr = 1'b0;
    chk("clr_acc3", acc_out, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ovf", ovf, 4'h0);
    led_sel = 2'd2; #1;
    chk("clr_acc2", acc_out, 0);

    // RST during ARM aborts with no update
    led_sel = 2'd0;
    send(8'd30, 2'd0, 0);
    chk("arm_busy", busy, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_acc", acc_out, 0);
    chk("rst_mid_led", led, 8'h00);
    step(); step();
    chk("rst_mid_late", acc_out, 0);

    // enable low blocks acceptance
    led_sel = 2'd1;
    enable = 1'b0; in_valid = 1'b1; in_data = 8'd40; in_ch = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dis_rdy", in_ready, 0);
      step();
    end
    chk("dis_acc", acc_out, 0);
    chk("dis_busy", busy, 0);
    enable = 1'b1;
    step();
    in_valid = 1'b0;
    chk("en_busy", busy, 1);
    step();
    enable = 1'b0;
    step();
    chk("en_acc", acc_out, 40);
    enable = 1'b1;

    // 16-bit boundary: 257 x 0xFF fills exactly, one more overflows
    RST = 1'b1; step(); RST = 1'b0;
    led_sel = 2'd1;
    for (int i = 0; i < 257; i++) send(8'hFF, 2'd1, 1);
    chk("full16_acc", acc_out16, 16'hFFFF);
    chk("full16_ovf", ovf16, 4'h0);
    chk("full32_acc", acc_out, 32'd65535);
    send(8'hFF, 2'd1, 1);
`ifdef LED_ACCUM_SAT_EN
    chk("ovf16_acc", acc_out16, 16'hFFFF);
    chk("ovf16_led", led16, 8'hFF);
`else
    chk("ovf16_acc", acc_out16, 16'h00FE);
    chk("ovf16_led", led16, 8'h00);
`endif
    chk("ovf16_flag", ovf16, 4'b0010);
    chk("ovf32_acc", acc_out, 32'h000100FE);
    chk("ovf32_flag", ovf, 4'h0);
    send(8'h10, 2'd1, 1);
    chk("ovf16_sticky", ovf16, 4'b0010);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr16_ovf", ovf16, 4'h0);
    chk("clr16_acc", acc_out16, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_accum_ctrl.md
LED_ACCUM_CTRL -- requirements
Module: led_accum_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8: sample width.
- NCH, 4: number of accumulator channels, at least 2.
- ACC_W, 32: accumulator width, at least 16.
- THRESH, 7: a sample is accumulated only if it is strictly greater than this value.
- SEL_THRESH, 11: LED high/low byte select threshold.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: clock. Reset is RST, synchronous, active-high, on CLK.
- RST, in, 1: synchronous active-high reset.
- enable, in, 1: permits sample acceptance.
- clr, in, 1: synchronous clear of all accumulators and flags.
- in_valid, in, 1: sample valid.
- in_ready, out, 1: block can accept a sample.
- in_data, in, DATA_W: sample value, unsigned.
- in_ch, in, $clog2(NCH): target channel.
- led_sel, in, $clog2(NCH): channel shown on led and acc_out.
- acc_out, out, ACC_W: accumulator of channel led_sel.
- ovf, out, NCH: sticky per-channel overflow flags.
- busy, out, 1: FSM not in IDLE.
- led, out, 8: LED display.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, ARM and ACCUM, encoded in a single registered state variable.
REQ-004 in_ready SHALL be 1 if and only if state is IDLE, enable is 1 and clr is 0.
REQ-005 A handshake SHALL occur at a rising edge where in_valid and in_ready are both 1.
REQ-006 On a handshake with in_data > THRESH, the block SHALL latch in_data and in_ch and go to ARM.
REQ-007 On a handshake with in_data <= THRESH, the sample SHALL be consumed and dropped, and the state SHALL remain IDLE.
REQ-008 ARM SHALL go unconditionally to ACCUM after one cycle. ACCUM SHALL go to IDLE after one cycle.
REQ-009 On leaving ACCUM, the block SHALL apply acc[ch] <= acc[ch] + latched data, zero-extended to ACC_W. It SHALL also set last_val <= latched data.
REQ-010 For a handshake at edge N, the accumulator update SHALL be visible at edge N+2. The next handshake SHALL be possible no earlier than edge N+3.
REQ-011 Deasserting enable while in ARM or ACCUM SHALL NOT abort the operation. enable SHALL only gate acceptance.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 acc_out SHALL equal acc[led_sel], combinationally from registers.
REQ-014 led SHALL equal acc[led_sel][15:8] when last_val > SEL_THRESH, otherwise acc[led_sel][7:0]. It SHALL be combinational from registers.
REQ-015 An addition whose true result exceeds 2^ACC_W-1 SHALL set ovf[ch] to 1. ovf[ch] SHALL stay set until RST or clr.
REQ-016 clr=1 SHALL, at that edge:
- zero all accumulators, ovf and last_val;
- discard any in-flight ARM or ACCUM operation, including a concurrent ACCUM update;
- force the state to IDLE.
REQ-017 If in_ch >= NCH, the sample SHALL be accepted and dropped, with no state change.
REQ-018 Accumulators of channels other than the latched channel SHALL never change, except on clr or RST.

Reset
REQ-019 While RST=1 at a rising edge, the block SHALL set state=IDLE, all acc=0, ovf=0, last_val=0, and the latched data and channel to 0.
REQ-020 RST SHALL have priority over clr and over any handshake. Asserting RST mid-operation SHALL abort the operation with no accumulator update.
REQ-021 After reset, outputs SHALL be: busy=0, acc_out=0, led=0x00, ovf=0. in_ready SHALL be 1 only when enable=1 and clr=0.

Configuration
REQ-022 Macro LED_ACCUM_SAT_EN defined: accumulation SHALL saturate at 2^ACC_W-1 instead of wrapping. ovf[ch] SHALL be set when saturation clips a sum.
REQ-023 Macro LED_ACCUM_SAT_EN undefined: accumulation SHALL wrap modulo 2^ACC_W. ovf[ch] SHALL be set on carry-out.

Verification (DATA_W=8, NCH=4, ACC_W=32 unless stated)
REQ-024 After reset, enable=1, handshake in_data=5, in_ch=0 -> acc[0]=0, busy stays 0, in_ready stays 1.
REQ-025 Handshake in_data=20, in_ch=2 at edge N, with led_sel=2 -> in_ready=0 for the cycles following edges N and N+1; acc_out=20 after edge N+2; led=0x00 (high byte). Then handshake 9 on channel 2 -> acc_out=29, led=0x1D (low byte).
REQ-026 With ACC_W=16, 257 samples of 0xFF on channel 1 give acc=0xFFFF and ovf[1]=0. One more 0xFF -> acc=0x00FE and ovf=4'b0010 without the macro; acc=0xFFFF and ovf=4'b0010 with LED_ACCUM_SAT_EN.
REQ-027 clr=1 in the ACCUM cycle of a sample 50 on channel 3, where acc[3]=10 -> next cycle acc[3]=0, all ovf=0, state IDLE, busy=0.
REQ-028 RST=1 during ARM for a sample 30 on channel 0 -> next cycle state IDLE, acc[0]=0, led=0x00, busy=0.
REQ-029 enable=0 in IDLE with in_valid=1 and in_data=40 for 5 cycles -> in_ready=0 throughout, no accumulator changes. Raise enable -> handshake and acc=40 two edges later.
